// File: rtl/issue_scheduler_pkg.sv
// Shared backend types for the issue scheduler: entry layout, default widths
// and the wakeup tag-match helper.
package issue_scheduler_pkg;

    localparam int SCHED_PREG_W = 6;
    localparam int SCHED_XLEN   = 32;

    typedef struct packed {
        logic                    valid;
        logic [SCHED_PREG_W-1:0] dst_preg;
        logic [SCHED_PREG_W-1:0] src1_preg;
        logic [SCHED_PREG_W-1:0] src2_preg;
        logic                    src1_rdy;
        logic                    src2_rdy;
        logic [SCHED_XLEN-1:0]   imm_val;
        logic [SCHED_XLEN-1:0]   pc;
    } sched_entry_t;

    // A source tag is woken by the external broadcast or by the internal
    // speculative broadcast of the micro-op being selected.
    function automatic logic tag_hit(
        input logic [SCHED_PREG_W-1:0] tag,
        input logic                    ext_valid,
        input logic [SCHED_PREG_W-1:0] ext_preg,
        input logic                    spec_valid,
        input logic [SCHED_PREG_W-1:0] spec_preg
    );
        return (ext_valid && (tag == ext_preg)) || (spec_valid && (tag == spec_preg));
    endfunction

endpackage

// File: rtl/issue_scheduler_select.sv
// Find-first priority picker: lowest-index request wins. Purely combinational
// so wider schedulers can stack several of these.
module issue_scheduler_select #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue age-ordered scheduler (compacting queue, entry 0 oldest).
// Optional macro SCHED_SPEC_WAKEUP_EN: the selected micro-op's destination is
// broadcast internally in its select cycle, enabling back-to-back issue.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = SCHED_PREG_W,
    parameter int XLEN   = SCHED_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PREG_W-1:0]          disp_dst_preg,
    input  logic [PREG_W-1:0]          disp_src1_preg,
    input  logic [PREG_W-1:0]          disp_src2_preg,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [XLEN-1:0]            disp_imm_val,
    input  logic [XLEN-1:0]            disp_pc,
    input  logic                       wakeup_valid,
    input  logic [PREG_W-1:0]          wakeup_preg,
    output logic                       fire_valid,
    output logic [PREG_W-1:0]          fire_dst_preg,
    output logic [PREG_W-1:0]          fire_src1_preg,
    output logic [PREG_W-1:0]          fire_src2_preg,
    output logic [XLEN-1:0]            fire_imm_val,
    output logic [XLEN-1:0]            fire_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sched_entry_t      q   [DEPTH];
    sched_entry_t      wk  [DEPTH];
    sched_entry_t      nq  [DEPTH];
    sched_entry_t      disp_ent;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     tail;
    logic [DEPTH-1:0]  req;
    logic [DEPTH-1:0]  grant;
    logic [IW-1:0]     sel_idx;
    logic              sel_any;
    logic              accept;
    logic              spec_valid;
    logic [PREG_W-1:0] spec_preg;

    assign count      = cnt_q;
    assign disp_ready = (cnt_q < CW'(DEPTH));
    assign accept     = disp_valid && disp_ready;

    // Eligibility uses registered ready bits only, so a wakeup reaches select a cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req[i] = q[i].valid && q[i].src1_rdy && q[i].src2_rdy;
        end
    end

    issue_scheduler_select #(
        .N  (DEPTH),
        .IW (IW)
    ) u_select (
        .req   (req),
        .grant (grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

`ifdef SCHED_SPEC_WAKEUP_EN
    assign spec_valid = sel_any;
    assign spec_preg  = q[sel_idx].dst_preg;
`else
    assign spec_valid = 1'b0;
    assign spec_preg  = '0;
`endif

    // Apply this cycle's wakeup tags to every resident entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk[i] = q[i];
            if (q[i].valid) begin
                if (tag_hit(q[i].src1_preg, wakeup_valid, wakeup_preg, spec_valid, spec_preg))
                    wk[i].src1_rdy = 1'b1;
                if (tag_hit(q[i].src2_preg, wakeup_valid, wakeup_preg, spec_valid, spec_preg))
                    wk[i].src2_rdy = 1'b1;
            end
        end
    end

    // Incoming micro-op sees the same wakeup tags so a same-cycle broadcast is not lost.
    always_comb begin
        disp_ent           = '0;
        disp_ent.valid     = 1'b1;
        disp_ent.dst_preg  = disp_dst_preg;
        disp_ent.src1_preg = disp_src1_preg;
        disp_ent.src2_preg = disp_src2_preg;
        disp_ent.src1_rdy  = disp_src1_rdy
                           | tag_hit(disp_src1_preg, wakeup_valid, wakeup_preg, spec_valid, spec_preg);
        disp_ent.src2_rdy  = disp_src2_rdy
                           | tag_hit(disp_src2_preg, wakeup_valid, wakeup_preg, spec_valid, spec_preg);
        disp_ent.imm_val   = disp_imm_val;
        disp_ent.pc        = disp_pc;
    end

    // Tail slot after compaction: a fire this cycle pulls the tail down by one.
    always_comb begin
        tail = sel_any ? (cnt_q - 1'b1) : cnt_q;
    end

    // Remove the fired entry by shifting younger entries down, then append the dispatch.
    always_comb begin
        logic shift;
        shift = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift = shift | grant[i];
            nq[i] = shift ? wk[i + 1] : wk[i];
        end
        nq[DEPTH-1] = sel_any ? '0 : wk[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (tail == CW'(i)))
                nq[i] = disp_ent;
        end
    end

    // Occupancy tracks accepts and fires; both or neither leaves it unchanged.
    always_comb begin
        case ({accept, sel_any})
            2'b10:   cnt_nxt = cnt_q + 1'b1;
            2'b01:   cnt_nxt = cnt_q - 1'b1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    // Queue, occupancy and fire packet registers; flush squashes everything but the fire payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            cnt_q          <= '0;
            fire_valid     <= 1'b0;
            fire_dst_preg  <= '0;
            fire_src1_preg <= '0;
            fire_src2_preg <= '0;
            fire_imm_val   <= '0;
            fire_pc        <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            cnt_q      <= '0;
            fire_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
            cnt_q      <= cnt_nxt;
            fire_valid <= sel_any;
            if (sel_any) begin
                fire_dst_preg  <= q[sel_idx].dst_preg;
                fire_src1_preg <= q[sel_idx].src1_preg;
                fire_src2_preg <= q[sel_idx].src2_preg;
                fire_imm_val   <= q[sel_idx].imm_val;
                fire_pc        <= q[sel_idx].pc;
            end
        end
    end

endmodule
